hps_node_capture: RTL
=====================

// Module: hps_node_capture
// PURPOSE
// Parametrised successor to the fixed two-node HPS bridge snooper. Watches the shared HPS
// memory bus for a trigger read, then captures NUM_REC node records (WORDS_PER_REC words each)
// from a read window into a flat MSB-first buffer. Reports per-record valid flags and an
// end-of-capture status (complete / terminated / timeout / cancelled). Feeds the A* pathfinding core.
// PARAMETERS
// DATA_W        16      bus data width; one record word
// ADDR_W        16      bus byte-address width
// WORDS_PER_REC 17      words per node record (x,y,id,parent,cost,6x child id/dist)
// NUM_REC       2       records per capture (2 = start+goal)
// TRIGGER_ADDR  16'h0398 byte address whose read arms a capture (bit 0 ignored)
// BASE_ADDR     16'h0800 byte address of record 0 word 0 (bit 0 ignored)
// TERMINATOR    16'hFFFF in-window read value that ends capture early
// TIMEOUT_CYC   4096    idle cycles in CAPTURE before timeout; 0 disables
// PORTS
// clk         in   1                          sole clock, rising edge
// reset_n     in   1                          synchronous, active-low reset
// io_enable   in   1                          high = IO cycle; capture only when low
// write_enable in  1                          high = write; capture only on reads
// address     in   ADDR_W                     bus byte address
// readdata    in   DATA_W                     bus read data
// cancel      in   1                          abort an in-progress capture
// records     out  NUM_REC*WORDS_PER_REC*DATA_W  captured words, rec0 word0 in MSBs
// rec_valid   out  NUM_REC                    bit k = every word of record k captured
// busy        out  1                          high in CAPTURE
// done        out  1                          one-cycle pulse at end of capture
// status      out  2                          00 none, 01 complete, 10 terminated, 11 timeout/cancel
// BEHAVIOUR
// - Reset (reset_n low at clk edge): state IDLE; records, rec_valid, status = 0; busy, done = 0; counters 0.
// - Qualifying read q = !write_enable && !io_enable. Word index i = (address[ADDR_W-1:1] - BASE_ADDR[ADDR_W-1:1]).
//   In-window iff 0 <= i < N, N = NUM_REC*WORDS_PER_REC. Record k = i / WORDS_PER_REC; word j = i % WORDS_PER_REC.
//   Slot i occupies records[(N-i)*DATA_W-1 -: DATA_W].
// - IDLE: on q && address[ADDR_W-1:1]==TRIGGER_ADDR[ADDR_W-1:1], go to CAPTURE next cycle.
//   Same edge: clear records, word mask, rec_valid, status, timeout counter. Non-trigger reads ignored.
// - CAPTURE (busy=1), priority order per cycle:
//   1. cancel: status<=11, go to DONE. Current word discarded.
//   2. q && in-window && readdata==TERMINATOR: word not stored; status<=10; go to DONE.
//   3. q && in-window: store word at slot i; set mask bit i; clear timeout counter.
//      Re-reads overwrite the slot. If i==N-1, status<=01 and go to DONE.
//      Completion is keyed on the last address, not on a full mask.
//   4. otherwise: timeout counter++. If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1,
//      status<=11 and go to DONE.
//   Out-of-window reads, writes and IO cycles do not store but do reset the timeout counter only
//   when in-window. The trigger address is not in the window.
// - DONE: done=1 and busy=0 for exactly one cycle. rec_valid[k] <= AND of mask bits for record k,
//   visible the same cycle as done.
//   Next state is CAPTURE if a trigger read occurs this cycle (buffers cleared as in IDLE), else IDLE.
// - records, rec_valid and status hold their values until the next trigger or reset.
// - Register update: data lands one cycle after the bus read. done asserts one cycle after the terminating event.
// - reset_n low mid-capture overrides everything: all outputs 0 on the next edge, no done pulse.
// - Widths: index subtract is ADDR_W-1 bits, unsigned. Underflow (address < BASE) wraps to
//   a value >= N and is treated as out of window.
// TESTING
// 1. Trigger read @0x0398, then reads 0x0800..0x0842 with data 0x0001..0x0022
//    -> done pulse 1 clk after the 0x0842 read; status=01; rec_valid=2'b11; records MSB word=0x0001, LSB word=0x0022.
// 2. Trigger, 5 reads from 0x0800, then read @0x080A returns 0xFFFF
//    -> status=10; rec_valid=00; slots 0-4 hold data; slot 5 keeps cleared value 0.
// 3. Trigger with TIMEOUT_CYC=16 and no further reads -> done 16 clks after CAPTURE entry; status=11.
// 4. Trigger, reads with write_enable=1 or io_enable=1 to 0x0800 -> not stored; then cancel=1
//    -> status=11; records all 0.
// 5. reset_n low for 1 clk mid-capture (after 10 words) -> all outputs 0; no done; IDLE;
//    a later trigger + full sequence yields status=01.
// 6. NUM_REC=4, WORDS_PER_REC=17 config, full sequence out of order ending @0x0886
//    -> status=01; rec_valid reflects only fully written records.

Source files
------------

// File: rtl/hps_node_capture.sv
// rtl/hps_node_capture.sv - HPS bus snooper capturing node records after a trigger read
// Watches qualifying bus reads, fills a flat MSB-first record buffer and reports end-of-capture status.
module hps_node_capture #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 16,
  parameter int                WORDS_PER_REC = 17,
  parameter int                NUM_REC       = 2,
  parameter logic [ADDR_W-1:0] TRIGGER_ADDR  = 16'h0398,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'h0800,
  parameter logic [DATA_W-1:0] TERMINATOR    = 16'hFFFF,
  parameter int                TIMEOUT_CYC   = 4096
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       io_enable,
  input  logic                                       write_enable,
  input  logic [ADDR_W-1:0]                          address,
  input  logic [DATA_W-1:0]                          readdata,
  input  logic                                       cancel,
  output logic [NUM_REC*WORDS_PER_REC*DATA_W-1:0]    records,
  output logic [NUM_REC-1:0]                         rec_valid,
  output logic                                       busy,
  output logic                                       done,
  output logic [1:0]                                 status
);

  localparam int N     = NUM_REC * WORDS_PER_REC;
  localparam int IW    = ADDR_W - 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [1:0] STAT_NONE     = 2'b00;
  localparam logic [1:0] STAT_COMPLETE = 2'b01;
  localparam logic [1:0] STAT_TERM     = 2'b10;
  localparam logic [1:0] STAT_ABORT    = 2'b11;

  logic [1:0]          state_q, state_d;
  logic [N*DATA_W-1:0] records_q, records_d;
  logic [N-1:0]        mask_q, mask_d;
  logic [NUM_REC-1:0]  rec_valid_q, rec_valid_d;
  logic [1:0]          status_q, status_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic          qual_rd;
  logic          trig;
  logic          in_win;
  logic [IW-1:0] idx;
  logic          start;

  // Word index wraps on underflow, so addresses below the base fall out of the window.
  assign idx     = address[ADDR_W-1:1] - BASE_ADDR[ADDR_W-1:1];
  assign in_win  = ({1'b0, idx} < ADDR_W'(N));
  assign qual_rd = !write_enable && !io_enable;
  assign trig    = qual_rd && (address[ADDR_W-1:1] == TRIGGER_ADDR[ADDR_W-1:1]);

  always_comb begin
    state_d     = state_q;
    records_d   = records_q;
    mask_d      = mask_q;
    rec_valid_d = rec_valid_q;
    status_d    = status_q;
    cnt_d       = cnt_q;
    start       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) start = 1'b1;
      end
      ST_CAPTURE: begin
        if (cancel) begin
          status_d = STAT_ABORT;
          state_d  = ST_DONE;
        end else if (qual_rd && in_win && (readdata == TERMINATOR)) begin
          status_d = STAT_TERM;
          state_d  = ST_DONE;
        end else if (qual_rd && in_win) begin
          for (int s = 0; s < N; s++) begin
            if (idx == IW'(s)) begin
              records_d[(N-s)*DATA_W-1 -: DATA_W] = readdata;
              mask_d[s] = 1'b1;
            end
          end
          cnt_d = '0;
          // Completion follows the last address, even if earlier slots were skipped.
          if (idx == IW'(N-1)) begin
            status_d = STAT_COMPLETE;
            state_d  = ST_DONE;
          end
        end else if (in_win) begin
          cnt_d = '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
          status_d = STAT_ABORT;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (trig) start = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Record flags are latched on entry to DONE so they appear alongside the done pulse.
    if ((state_q == ST_CAPTURE) && (state_d == ST_DONE)) begin
      for (int k = 0; k < NUM_REC; k++) begin
        rec_valid_d[k] = &mask_d[k*WORDS_PER_REC +: WORDS_PER_REC];
      end
    end

    if (start) begin
      state_d     = ST_CAPTURE;
      records_d   = '0;
      mask_d      = '0;
      rec_valid_d = '0;
      status_d    = STAT_NONE;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      records_q   <= '0;
      mask_q      <= '0;
      rec_valid_q <= '0;
      status_q    <= STAT_NONE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      records_q   <= records_d;
      mask_q      <= mask_d;
      rec_valid_q <= rec_valid_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
    end
  end

  assign records   = records_q;
  assign rec_valid = rec_valid_q;
  assign status    = status_q;
  assign busy      = (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);

endmodule
